// File: rtl/smj_pkg.sv
// Shared types, constants and tile-validity helper for the 5-tile hand judge.
package smj_pkg;

    typedef logic [5:0] tile_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        JUDGE   = 2'd2,
        HOLD    = 2'd3
    } state_e;

    localparam tile_t       TILE_INVALID = 6'b001111;
    localparam logic [1:0]  VERDICT_FOUL = 2'b01;
    localparam logic [1:0]  VERDICT_OK   = 2'b00;
    localparam int          HAND_SIZE    = 5;

    function automatic logic is_invalid_tile(input tile_t t);
        return (t == 6'b000111) || (t == 6'b001000) || (t[3:0] >= 4'd9);
    endfunction

endpackage

// File: rtl/smj_judge.sv
// Combinational hand judge: foul if any tile is invalid or all five match.
module smj_judge
    import smj_pkg::*;
(
    input  tile_t      n0,
    input  tile_t      n1,
    input  tile_t      n2,
    input  tile_t      n3,
    input  tile_t      n4,
    output logic [1:0] verdict
);

    tile_t m0, m1, m2, m3, m4;
    logic  any_bad;
    logic  all_eq;

    always_comb begin
        m0 = is_invalid_tile(n0) ? TILE_INVALID : n0;
        m1 = is_invalid_tile(n1) ? TILE_INVALID : n1;
        m2 = is_invalid_tile(n2) ? TILE_INVALID : n2;
        m3 = is_invalid_tile(n3) ? TILE_INVALID : n3;
        m4 = is_invalid_tile(n4) ? TILE_INVALID : n4;
        any_bad = (m0 == TILE_INVALID) || (m1 == TILE_INVALID) || (m2 == TILE_INVALID)
               || (m3 == TILE_INVALID) || (m4 == TILE_INVALID);
        all_eq  = (m0 == m1) && (m0 == m2) && (m0 == m3) && (m0 == m4);
        verdict = (any_bad || all_eq) ? VERDICT_FOUL : VERDICT_OK;
    end

endmodule

// File: rtl/smj_hand_ctrl.sv
// Tile-stream sequencer: assembles 5-tile hands, judges them, returns a verdict.
// Define SMJ_STATS_EN to add the saturating hand_cnt / foul_cnt statistics.
//
// state   | meaning
// IDLE    | waiting for the first tile of a hand
// COLLECT | tiles 2..5 arriving, inter-tile timeout armed
// JUDGE   | register the verdict of the full hand
// HOLD    | verdict offered until downstream takes it
module smj_hand_ctrl
    import smj_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_tile,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_data,
    output logic             err_timeout
`ifdef SMJ_STATS_EN
    ,
    output logic [CNT_W-1:0] hand_cnt,
    output logic [CNT_W-1:0] foul_cnt
`endif
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
    localparam logic [2:0]    IDX_LAST = 3'(HAND_SIZE - 1);

    state_e          state_q;
    logic [2:0]      idx_q;
    logic [TW-1:0]   timer_q;
    tile_t           slot_q [HAND_SIZE];
    logic            in_ready_q;
    logic            out_valid_q;
    logic [1:0]      out_data_q;
    logic            err_q;
    logic [1:0]      verdict;
    logic            accept;
    logic            handshake;

    assign accept    = in_valid && in_ready_q;
    assign handshake = out_valid_q && out_ready;

    smj_judge u_judge (
        .n0      (slot_q[0]),
        .n1      (slot_q[1]),
        .n2      (slot_q[2]),
        .n3      (slot_q[3]),
        .n4      (slot_q[4]),
        .verdict (verdict)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            timer_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= VERDICT_OK;
            err_q       <= 1'b0;
            for (int i = 0; i < HAND_SIZE; i++) slot_q[i] <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    timer_q    <= '0;
                    if (accept) begin
                        slot_q[0] <= in_tile;
                        idx_q     <= 3'd1;
                        state_q   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        slot_q[idx_q] <= in_tile;
                        timer_q       <= '0;
                        if (idx_q == IDX_LAST) begin
                            in_ready_q <= 1'b0;
                            state_q    <= JUDGE;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else if (TIMEOUT != 0) begin
                        // Expiry only on a no-accept cycle, so a late tile always wins.
                        if (timer_q == TO_LAST) begin
                            err_q   <= 1'b1;
                            idx_q   <= '0;
                            timer_q <= '0;
                            state_q <= IDLE;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                end
                JUDGE: begin
                    in_ready_q  <= 1'b0;
                    out_data_q  <= verdict;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        idx_q       <= '0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign err_timeout = err_q;

`ifdef SMJ_STATS_EN
    logic [CNT_W-1:0] hand_cnt_q;
    logic [CNT_W-1:0] foul_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hand_cnt_q <= '0;
            foul_cnt_q <= '0;
        end else if (handshake) begin
            if (hand_cnt_q != '1) hand_cnt_q <= hand_cnt_q + 1'b1;
            if ((out_data_q == VERDICT_FOUL) && (foul_cnt_q != '1)) foul_cnt_q <= foul_cnt_q + 1'b1;
        end
    end

    assign hand_cnt = hand_cnt_q;
    assign foul_cnt = foul_cnt_q;
`endif

endmodule

// File: doc/smj_hand_ctrl.md
Name: smj_hand_ctrl

Overview:
- Sequencer for the 5-tile hand judge.
- Accepts tiles one per handshake on a serial stream and assembles them into a 5-tile hand (slots n0..n4, in arrival order).
- Presents the hand to the judge and returns a registered 2-bit verdict on a valid/ready output channel.
- Sits between the tile-stream source and the downstream scorer; enforces an inter-tile timeout so a stalled source cannot wedge the hand buffer.

Parameters:
- TIMEOUT, 16, max idle cycles between tiles inside a partial hand; 0 disables the timeout.
- CNT_W, 8, width of the statistics counters (SMJ_STATS_EN only).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  tile present on in_tile
- in_ready  out  1  controller can accept a tile
- in_tile  in  6  tile code: [5:4] suit, [3:0] rank
- out_valid  out  1  verdict available
- out_ready  in  1  downstream accepts verdict
- out_data  out  2  verdict: 2'b01 = foul, 2'b00 = legal
- err_timeout  out  1  one-cycle pulse: partial hand discarded
- hand_cnt  out  CNT_W  hands judged (SMJ_STATS_EN only)
- foul_cnt  out  CNT_W  hands judged foul (SMJ_STATS_EN only)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, slot index=0, idle timer=0, all 5 slots=6'b0, in_ready=0, out_valid=0, out_data=2'b00, err_timeout=0, counters=0. Reset mid-hand discards the partial hand; no verdict is produced for it.
- Tile validity: a tile is invalid if its code is 6'b000111 or 6'b001000, or if [3:0] is in 9..15 (any suit). Invalid tiles are stored unchanged; the judge maps each one to the sentinel 6'b001111.
- Judge (combinational): foul=1 if any mapped slot equals 6'b001111, or if all 5 mapped slots are equal. out_data={1'b0,foul}.
- States:
  - IDLE: in_ready=1. On accept, write slot0, index=1, go to COLLECT.
  - COLLECT: in_ready=1. On accept, write slot[index] and increment index. On accepting the 5th tile (index==4), go to JUDGE.
  - JUDGE: in_ready=0. Register the verdict into out_data, set out_valid=1, go to HOLD.
  - HOLD: in_ready=0. out_valid and out_data are held stable until out_ready=1. On out_valid&&out_ready, clear out_valid, index=0, go to IDLE.
- Latency: the 5th tile is accepted on edge N; out_valid is high after edge N+1. Minimum hand period is 7 cycles with out_ready tied high (5 accept cycles + JUDGE + HOLD handshake).
- Timeout:
  - The idle timer counts only in COLLECT on cycles with no accept, and clears on any accept.
  - When the timer reaches TIMEOUT: err_timeout=1 for one cycle, index=0, timer=0, go to IDLE. No verdict is produced.
  - If a tile is accepted on the same cycle the timer would expire, the accept wins and there is no timeout.
  - IDLE never times out. TIMEOUT=0 disables the timer entirely.
- Slots are not cleared between hands; each new hand overwrites them in order.
- in_tile is sampled only when in_valid&&in_ready.

Optional Feature:
- Macro: SMJ_STATS_EN.
- Defined:
  - hand_cnt and foul_cnt ports exist.
  - Both counters update on each out_valid&&out_ready: hand_cnt+1 always, foul_cnt+1 if out_data==2'b01.
  - Both counters saturate at all-ones; they do not wrap.
  - Timed-out hands are not counted.
- Undefined: both ports and all counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package smj_pkg:
  - typedef tile_t (logic [5:0]);
  - typedef state_e (IDLE, COLLECT, JUDGE, HOLD);
  - constants TILE_INVALID=6'b001111, VERDICT_FOUL=2'b01, VERDICT_OK=2'b00, HAND_SIZE=5;
  - function is_invalid_tile().
- One sub-module, smj_judge: purely combinational; 5 tile_t inputs, 2-bit verdict output. The controller instantiates it on the slot registers.

Test Plan:
- Legal hand 6'h11,6'h12,6'h13,6'h21,6'h05 streamed back-to-back, out_ready=1 -> out_valid one cycle after the 5th accept, out_data=2'b00, then return to IDLE with in_ready=1.
- Five copies of 6'h23 -> out_data=2'b01 (all equal). Tiles 6'h01,6'h02,6'h07,6'h03,6'h04 -> out_data=2'b01 (6'h07 invalid). Tile 6'h3A in slot 4 -> 2'b01.
- out_ready=0 for 10 cycles after verdict -> out_valid and out_data stable, in_ready=0, in_valid tiles ignored. Release -> accepted once, next hand proceeds normally.
- TIMEOUT=4: two tiles, then idle 4 cycles -> err_timeout one-cycle pulse, no out_valid. Next 5 tiles form a fresh hand with the correct verdict. A tile arriving on the expiry cycle is accepted and no pulse occurs.
- rst_n low after 3 tiles -> outputs at reset values immediately. After release, a full new hand judges correctly with no stale slot effects.
- SMJ_STATS_EN, 3 hands (legal, foul, foul) -> hand_cnt=3, foul_cnt=2. CNT_W=2 with 5 hands -> hand_cnt saturates at 3.
